items_manager: RTL and testbench

Responder side of the controller's items-reload handshake, and owner of the maze's collectible items. On a reload request it copies the level template (dots and power pellets) from an external ROM into an internal item RAM. It counts the collectible tiles and returns a one-cycle done pulse. During play it clears tiles that Pac-Man enters, reports each dot or pellet eaten, and raises dot-clear when no collectibles remain. The block sits between the game controller, the item template ROM, the Pac-Man movement logic and the renderer.

---
 rtl/items_manager_pkg.sv | 29 ++
 rtl/items_manager_item_ram.sv | 50 +++++
 rtl/items_manager.sv | 178 +++++++++++++++++
 tb/tb_items_manager.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/items_manager_pkg.sv
// rtl/items_manager_pkg.sv - item codes, manager state encoding and helpers
//
// Purpose: shared definitions for the items manager and its item RAM.
// Ports: none (package).

package items_manager_pkg;

  localparam logic [1:0] IT_NONE  = 2'd0;
  localparam logic [1:0] IT_DOT   = 2'd1;
  localparam logic [1:0] IT_POWER = 2'd2;
  localparam logic [1:0] IT_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    IM_IDLE  = 2'd0,
    IM_LOAD  = 2'd1,
    IM_DONE  = 2'd2,
    IM_READY = 2'd3
  } im_state_e;

  function automatic logic is_collectible(input logic [1:0] code);
    return (code == IT_DOT) || (code == IT_POWER);
  endfunction

  // The reserved code never reaches the RAM; it is stored as an empty tile.
  function automatic logic [1:0] sanitize_code(input logic [1:0] code);
    return (code == IT_RSVD) ? IT_NONE : code;
  endfunction

endpackage

// File: rtl/items_manager_item_ram.sv
// rtl/items_manager_item_ram.sv - 2-bit item RAM, one write plus two registered reads
//
// Purpose: holds the item code of every maze tile.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset (read registers only)
//   i_a_we/waddr/wdata  port A write (loader or eat pipeline clear)
//   i_a_raddr/o_a_rdata port A registered read (eat pipeline stage 1)
//   i_b_addr/o_b_rdata  port B registered read (renderer)

module item_ram
  import items_manager_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_waddr,
  input  logic [1:0]        i_a_wdata,
  input  logic [ADDR_W-1:0] i_a_raddr,
  output logic [1:0]        o_a_rdata,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [1:0]        o_b_rdata
);

  logic [1:0] mem_q [2**ADDR_W];
  logic [1:0] a_rdata_q;
  logic [1:0] b_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_a_we) begin
      mem_q[i_a_waddr] <= i_a_wdata;
    end
  end

  // Read-first: a read colliding with a write returns the old contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_rdata_q <= IT_NONE;
      b_rdata_q <= IT_NONE;
    end else begin
      a_rdata_q <= mem_q[i_a_raddr];
      b_rdata_q <= mem_q[i_b_addr];
    end
  end

  assign o_a_rdata = a_rdata_q;
  assign o_b_rdata = b_rdata_q;

endmodule

// File: rtl/items_manager.sv
// rtl/items_manager.sv - maze item owner: template reload, eat pipeline, dot counting
//
// Purpose: loads the item template into the item RAM on a reload edge, pulses
// done, then clears eaten tiles and tracks the remaining collectible count.
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_items_reload/o_items_reload_done reload handshake with the game controller
//   o_tmpl_addr/i_tmpl_data           template ROM (1-cycle read latency)
//   i_eat_valid/i_eat_x/i_eat_y       tile entered by Pac-Man
//   o_eat_dot/o_eat_power             one-cycle eat pulses
//   i_rd_x/i_rd_y/o_rd_item           renderer read port (1-cycle latency)
//   o_dots_left/o_dot_clear           remaining collectibles, all-eaten level

module items_manager
  import items_manager_pkg::*;
#(
  parameter int MAP_W  = 28,
  parameter int MAP_H  = 31,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_items_reload,
  output logic              o_items_reload_done,
  output logic [ADDR_W-1:0] o_tmpl_addr,
  input  logic [1:0]        i_tmpl_data,
  input  logic              i_eat_valid,
  input  logic [4:0]        i_eat_x,
  input  logic [4:0]        i_eat_y,
  output logic              o_eat_dot,
  output logic              o_eat_power,
  input  logic [4:0]        i_rd_x,
  input  logic [4:0]        i_rd_y,
  output logic [1:0]        o_rd_item,
  output logic [ADDR_W-1:0] o_dots_left,
  output logic              o_dot_clear
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_W * MAP_H - 1);

  im_state_e         state_q;
  logic              reload_q;
  logic              sweep_q;
  logic [ADDR_W-1:0] tmpl_addr_q;
  logic              ld_wr_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic              done_q;
  logic [ADDR_W-1:0] dots_q;
  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic              s2_fwd_q;
  logic              eat_dot_q;
  logic              eat_power_q;

  logic              reload_edge;
  logic [ADDR_W-1:0] eat_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              eat_in_map;
  logic              eat_ok;
  logic [1:0]        a_rdata;
  logic [1:0]        s2_code;
  logic              s2_hit;
  logic [1:0]        ld_code;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0]        ram_wdata;

  assign reload_edge = i_items_reload & ~reload_q;
  assign eat_addr    = ADDR_W'(i_eat_y) * ADDR_W'(MAP_W) + ADDR_W'(i_eat_x);
  assign rd_addr     = ADDR_W'(i_rd_y) * ADDR_W'(MAP_W) + ADDR_W'(i_rd_x);
  assign eat_in_map  = ({27'd0, i_eat_x} < 32'(MAP_W)) && ({27'd0, i_eat_y} < 32'(MAP_H));
  assign eat_ok      = i_eat_valid && eat_in_map && (state_q == IM_READY) && !reload_edge;

  // A clear written by stage 2 on the same edge stage 1 reads that tile is
  // invisible to the read-first RAM, so it is forwarded as an empty tile.
  assign s2_code = s2_fwd_q ? IT_NONE : a_rdata;
  assign s2_hit  = s2_valid_q && is_collectible(s2_code) && !reload_edge;
  assign ld_code = sanitize_code(i_tmpl_data);

  // s2_valid_q is never set outside READY, so loader and eat writes are exclusive.
  assign ram_we    = ((state_q == IM_LOAD) && ld_wr_q) || s2_hit;
  assign ram_waddr = (state_q == IM_LOAD) ? ld_addr_q : s2_addr_q;
  assign ram_wdata = (state_q == IM_LOAD) ? ld_code : IT_NONE;

  item_ram #(.ADDR_W(ADDR_W)) u_item_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_a_we    (ram_we),
    .i_a_waddr (ram_waddr),
    .i_a_wdata (ram_wdata),
    .i_a_raddr (eat_addr),
    .o_a_rdata (a_rdata),
    .i_b_addr  (rd_addr),
    .o_b_rdata (o_rd_item)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IM_IDLE;
      reload_q    <= 1'b0;
      sweep_q     <= 1'b0;
      tmpl_addr_q <= '0;
      ld_wr_q     <= 1'b0;
      ld_addr_q   <= '0;
      done_q      <= 1'b0;
      dots_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_fwd_q    <= 1'b0;
      eat_dot_q   <= 1'b0;
      eat_power_q <= 1'b0;
    end else begin
      reload_q    <= i_items_reload;
      done_q      <= 1'b0;
      eat_dot_q   <= 1'b0;
      eat_power_q <= 1'b0;
      ld_wr_q     <= 1'b0;
      s2_valid_q  <= eat_ok;
      s2_addr_q   <= eat_addr;
      s2_fwd_q    <= s2_hit && (s2_addr_q == eat_addr);
      case (state_q)
        IM_IDLE: begin
          if (reload_edge) begin
            state_q     <= IM_LOAD;
            dots_q      <= '0;
            tmpl_addr_q <= '0;
            sweep_q     <= 1'b1;
          end
        end
        IM_LOAD: begin
          // Address issue runs one cycle ahead of the matching RAM write.
          ld_wr_q   <= sweep_q;
          ld_addr_q <= tmpl_addr_q;
          if (sweep_q) begin
            if (tmpl_addr_q == LAST_ADDR) begin
              sweep_q <= 1'b0;
            end else begin
              tmpl_addr_q <= tmpl_addr_q + 1'b1;
            end
          end
          if (ld_wr_q) begin
            if (is_collectible(ld_code)) begin
              dots_q <= dots_q + 1'b1;
            end
            if (ld_addr_q == LAST_ADDR) begin
              state_q <= IM_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        IM_DONE: begin
          state_q <= IM_READY;
        end
        IM_READY: begin
          if (reload_edge) begin
            state_q     <= IM_LOAD;
            dots_q      <= '0;
            tmpl_addr_q <= '0;
            sweep_q     <= 1'b1;
          end else if (s2_hit) begin
            dots_q      <= dots_q - 1'b1;
            eat_dot_q   <= (s2_code == IT_DOT);
            eat_power_q <= (s2_code == IT_POWER);
          end
        end
        default: state_q <= IM_IDLE;
      endcase
    end
  end

  assign o_items_reload_done = done_q;
  assign o_tmpl_addr         = tmpl_addr_q;
  assign o_eat_dot           = eat_dot_q;
  assign o_eat_power         = eat_power_q;
  assign o_dots_left         = dots_q;
  assign o_dot_clear         = (state_q == IM_READY) && (dots_q == '0);

endmodule

// File: tb/tb_items_manager.sv
// tb/tb_items_manager.sv - directed self-checking bench for items_manager

module tb_items_manager;

  logic       clk;
  logic       rst;
  logic       reload;
  logic       done;
  logic [2:0] tmpl_addr;
  logic [1:0] tmpl_data;
  logic       eat_valid;
  logic [4:0] eat_x;
  logic [4:0] eat_y;
  logic       eat_dot;
  logic       eat_power;
  logic [4:0] rd_x;
  logic [4:0] rd_y;
  logic [1:0] rd_item;
  logic [2:0] dots_left;
  logic       dot_clear;

  int errors = 0;
  int checks = 0;

  logic [1:0] rom [8];

  items_manager #(.MAP_W(4), .MAP_H(2), .ADDR_W(3)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_items_reload      (reload),
    .o_items_reload_done (done),
    .o_tmpl_addr         (tmpl_addr),
    .i_tmpl_data         (tmpl_data),
    .i_eat_valid         (eat_valid),
    .i_eat_x             (eat_x),
    .i_eat_y             (eat_y),
    .o_eat_dot           (eat_dot),
    .o_eat_power         (eat_power),
    .i_rd_x              (rd_x),
    .i_rd_y              (rd_y),
    .o_rd_item           (rd_item),
    .o_dots_left         (dots_left),
    .o_dot_clear         (dot_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Template ROM with one cycle of read latency.
  always @(posedge clk) tmpl_data <= rom[tmpl_addr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_eat(input logic v, input int x, input int y);
    eat_valid = v;
    eat_x = 5'(x);
    eat_y = 5'(y);
  endtask

  initial begin
    rom[0] = 2'd1; rom[1] = 2'd0; rom[2] = 2'd1; rom[3] = 2'd2;
    rom[4] = 2'd0; rom[5] = 2'd3; rom[6] = 2'd1; rom[7] = 2'd0;
    rst = 1'b1; reload = 1'b0; tmpl_data = 2'd0;
    set_eat(1'b0, 0, 0);
    rd_x = 5'd0; rd_y = 5'd0;
    tick(); tick();
    chk("rst_tmpl_addr", tmpl_addr, 0);
    chk("rst_rd_item", rd_item, 0);
    chk("rst_dots_left", dots_left, 0);
    chk("rst_done", done, 0);
    chk("rst_eat_pulses", {eat_dot, eat_power}, 0);
    chk("rst_dot_clear", dot_clear, 0);
    rst = 1'b0;

    // Eats in IDLE are ignored.
    tick();
    set_eat(1'b1, 0, 0);
    tick();
    set_eat(1'b0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_eat_pulses", {eat_dot, eat_power}, 0);
      chk("idle_dot_clear", dot_clear, 0);
    end

    // Reload edge in cycle 0; eats during LOAD are ignored.
    reload = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c <= 8) chk("load_tmpl_addr", tmpl_addr, c - 1);
      chk("load_done", done, (c == 10));
      chk("load_eat_pulses", {eat_dot, eat_power}, 0);
      if (c == 10) chk("load_dots_left", dots_left, 4);
      if (c == 2) set_eat(1'b1, 0, 0);
      if (c == 5) set_eat(1'b0, 0, 0);
    end
    chk("ready_dots_left", dots_left, 4);
    chk("ready_dot_clear", dot_clear, 0);

    // Renderer reads.
    rd_x = 5'd1; rd_y = 5'd1; tick();
    chk("rd_addr5_rsvd", rd_item, 0);
    rd_x = 5'd3; rd_y = 5'd0; tick();
    chk("rd_addr3", rd_item, 2);
    rd_x = 5'd2; rd_y = 5'd1; tick();
    chk("rd_addr6", rd_item, 1);
    rd_x = 5'd0; rd_y = 5'd0; tick();
    chk("rd_addr0", rd_item, 1);

    // Held reload level: no new sweep or done pulse.
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("hold_done", done, 0);
      chk("hold_dots_left", dots_left, 4);
    end

    // Off-map eats alias onto real tiles if not rejected.
    set_eat(1'b1, 4, 0); tick();
    set_eat(1'b1, 4, 1); tick();
    set_eat(1'b1, 0, 2); tick();
    set_eat(1'b0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("oob_eat_pulses", {eat_dot, eat_power}, 0);
      chk("oob_dots_left", dots_left, 4);
    end

    // Eat the dot at (0,0).
    set_eat(1'b1, 0, 0); tick();
    set_eat(1'b0, 0, 0);
    chk("eat00_early", eat_dot, 0);
    tick();
    chk("eat00_dot", eat_dot, 1);
    chk("eat00_power", eat_power, 0);
    chk("eat00_dots_left", dots_left, 3);
    rd_x = 5'd0; rd_y = 5'd0; tick();
    chk("eat00_dot_off", eat_dot, 0);
    chk("eat00_rd_item", rd_item, 0);

    // Back-to-back eats of the power pellet at (3,0).
    set_eat(1'b1, 3, 0); tick();
    set_eat(1'b1, 3, 0); tick();
    set_eat(1'b0, 0, 0);
    chk("pow_first", eat_power, 1);
    chk("pow_dots_left1", dots_left, 2);
    tick();
    chk("pow_second", eat_power, 0);
    chk("pow_second_dot", eat_dot, 0);
    chk("pow_dots_left2", dots_left, 2);

    // Re-eating an emptied tile does nothing.
    set_eat(1'b1, 0, 0); tick();
    set_eat(1'b0, 0, 0); tick();
    chk("reeat_pulses", {eat_dot, eat_power}, 0);
    chk("reeat_dots_left", dots_left, 2);

    // Last two dots, back to back at different tiles.
    set_eat(1'b1, 2, 0); tick();
    set_eat(1'b1, 2, 1); tick();
    set_eat(1'b0, 0, 0);
    chk("last_dot1", eat_dot, 1);
    chk("last_dots_left1", dots_left, 1);
    chk("last_clear1", dot_clear, 0);
    tick();
    chk("last_dot2", eat_dot, 1);
    chk("last_dots_left0", dots_left, 0);
    chk("last_clear_rise", dot_clear, 1);
    tick();
    chk("last_clear_hold", dot_clear, 1);
    chk("last_dot_off", eat_dot, 0);

    // New reload edge drops dot-clear as LOAD is entered.
    reload = 1'b0; tick();
    chk("rl_clear_before", dot_clear, 1);
    reload = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("rl_dot_clear", dot_clear, 0);
      chk("rl_tmpl_addr", tmpl_addr, c - 1);
    end

    // Reset in cycle 4 of LOAD.
    rst = 1'b1;
    reload = 1'b0;
    #1;
    chk("mrst_tmpl_addr", tmpl_addr, 0);
    chk("mrst_dots_left", dots_left, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rd_item", rd_item, 0);
    chk("mrst_pulses", {eat_dot, eat_power}, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("mrst_no_done", done, 0);
      chk("mrst_idle_addr", tmpl_addr, 0);
      chk("mrst_idle_clear", dot_clear, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
